// File: rtl/ising_pkg.sv
// ising_pkg: shared state type, spin decode and accumulator width derivation for the Ising readout
package ising_pkg;
  typedef enum logic {IDLE, ACCUM} state_t;
  localparam int PHASE_W = 64;
  function automatic int acc_width(input int dw, input int n);
    return dw + 2 * $clog2(n);
  endfunction
  // cos(2*pi*phase) >= 0 exactly when the top two fractional bits are equal
  function automatic logic spin_of(input logic [PHASE_W-1:0] p, input int fb);
    logic [PHASE_W-1:0] t;
    t = p >> (fb - 2);
    return t[1] ~^ t[0];
  endfunction
endpackage

// File: rtl/ising_pair_counter.sv
// ising_pair_counter: walks (i,j) over the strict upper triangle, i<j, row-major
//   init_i: restart at (0,1); advance_i: step to the next pair
//   i_o/j_o: current pair; first_o/last_o: flags for (0,1) and (N-2,N-1)
module ising_pair_counter #(
  parameter int N  = 16,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          init_i,
  input  logic          advance_i,
  output logic [IW-1:0] i_o,
  output logic [IW-1:0] j_o,
  output logic          first_o,
  output logic          last_o
);
  logic [IW-1:0] i_q, j_q;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      i_q <= '0;
      j_q <= '0;
    end else if (init_i) begin
      i_q <= '0;
      j_q <= IW'(1);
    end else if (advance_i) begin
      i_q <= (j_q == IW'(N - 1)) ? i_q + IW'(1) : i_q;
      j_q <= (j_q == IW'(N - 1)) ? i_q + IW'(2) : j_q + IW'(1);
    end
  assign i_o     = i_q;
  assign j_o     = j_q;
  assign first_o = (i_q == '0) && (j_q == IW'(1));
  assign last_o  = (i_q == IW'(N - 2)) && (j_q == IW'(N - 1));
endmodule

// File: rtl/ising_readout.sv
// ising_readout: decodes final oscillator phases to spins and accumulates the Ising energy
//   start: latch spins and run one pass over all i<j pairs (ignored while busy)
//   couplingMatrix/finalPhases: J[i][j] and phases, fixed point with fractionalBits
//   spins/energy: last result, held until the next start; busy/valid: pass running / result ready
module ising_readout import ising_pkg::*; #(
  parameter int N              = 16,
  parameter int fractionalBits = 16,
  parameter int dataWidth      = 32,
  parameter int ACC_WIDTH      = acc_width(dataWidth, N)
) (
  input  logic                        clk,
  input  logic                        n_rst,
  input  logic                        start,
  input  logic signed [dataWidth-1:0] couplingMatrix [N][N],
  input  logic signed [dataWidth-1:0] finalPhases [N],
  output logic        [N-1:0]         spins,
  output logic signed [ACC_WIDTH-1:0] energy,
  output logic                        busy,
  output logic                        valid
);
  localparam int IW = $clog2(N);
  if (N < 2) begin : g_n_check
    $error("ising_readout: N must be >= 2");
  end
  state_t                 state_q;
  logic [N-1:0]           dec;
  logic [IW-1:0]          pi, pj;
  logic                   first, last;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d, term, base;
  for (genvar k = 0; k < N; k++) begin : g_dec
    assign dec[k] = spin_of(PHASE_W'(finalPhases[k]), fractionalBits);
  end
  ising_pair_counter #(.N(N), .IW(IW)) u_pairs (
    .clk      (clk),
    .n_rst    (n_rst),
    .init_i   (state_q == IDLE && start),
    .advance_i(state_q == ACCUM),
    .i_o      (pi),
    .j_o      (pj),
    .first_o  (first),
    .last_o   (last)
  );
  // -J*s_i*s_j as add/subtract: equal spins subtract J, opposite spins add it
  always_comb begin
    term  = ACC_WIDTH'(couplingMatrix[pi][pj]);
    base  = first ? '0 : acc_q;
    acc_d = (spins[pi] == spins[pj]) ? base - term : base + term;
  end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state_q <= IDLE;
      spins   <= '0;
      energy  <= '0;
      acc_q   <= '0;
      busy    <= 1'b0;
      valid   <= 1'b0;
    end else if (state_q == IDLE) begin
      if (start) begin
        spins   <= dec;
        acc_q   <= '0;
        busy    <= 1'b1;
        valid   <= 1'b0;
        state_q <= ACCUM;
      end
    end else begin
      acc_q <= acc_d;
      if (last) begin
        energy  <= acc_d;
        valid   <= 1'b1;
        busy    <= 1'b0;
        state_q <= IDLE;
      end
    end
endmodule

// File: tb/tb_ising_readout.sv
// tb_ising_readout: randomized and directed checks of ising_readout against a pairwise-sum model
module tb_ising_readout;
  localparam int N = 4, FB = 16, DW = 32, AW = DW + 2 * $clog2(N), P = N * (N - 1) / 2;
  logic clk = 1'b0, n_rst = 1'b0, start = 1'b0;
  logic signed [DW-1:0] J [N][N];
  logic signed [DW-1:0] ph [N];
  logic [N-1:0] spins;
  logic signed [AW-1:0] energy;
  logic busy, valid;
  int vec = 0, err = 0;

  ising_readout #(.N(N), .fractionalBits(FB), .dataWidth(DW)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .couplingMatrix(J), .finalPhases(ph),
    .spins(spins), .energy(energy), .busy(busy), .valid(valid));

  always #5 clk = ~clk;

  function automatic logic [N-1:0] ref_spins();
    logic [N-1:0] s;
    for (int k = 0; k < N; k++) begin
      int unsigned f;
      f = ph[k] & 32'h0000FFFF;
      s[k] = (f < 32'h4000) || (f >= 32'hC000);
    end
    return s;
  endfunction

  function automatic longint ref_energy();
    logic [N-1:0] s;
    longint e;
    s = ref_spins();
    e = 0;
    for (int a = 0; a < N; a++)
      for (int b = a + 1; b < N; b++)
        e -= longint'(J[a][b]) * (s[a] == s[b] ? 1 : -1);
    return e;
  endfunction

  task automatic set_j(input logic signed [DW-1:0] up, input logic signed [DW-1:0] dg,
                       input logic signed [DW-1:0] lo);
    for (int a = 0; a < N; a++)
      for (int b = 0; b < N; b++)
        J[a][b] = (a < b) ? up : (a == b) ? dg : lo;
  endtask

  task automatic set_ph(input logic [DW-1:0] p0, input logic [DW-1:0] p1,
                        input logic [DW-1:0] p2, input logic [DW-1:0] p3);
    ph[0] = p0; ph[1] = p1; ph[2] = p2; ph[3] = p3;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_valid(output int c);
    c = 0;
    while (!valid && c < 40) begin
      @(negedge clk);
      c++;
    end
  endtask

  task automatic run_and_check(input string name);
    int c;
    logic [N-1:0] es;
    longint ee;
    es = ref_spins();
    ee = ref_energy();
    pulse_start();
    vec++;
    if (busy !== 1'b1 || valid !== 1'b0 || spins !== es) begin
      err++;
      $display("FAIL %s start: busy=%b valid=%b spins=%b, required busy=1 valid=0 spins=%b", name, busy, valid, spins, es);
    end
    wait_valid(c);
    vec++;
    if (c != P || energy !== AW'(ee) || busy !== 1'b0) begin
      err++;
      $display("FAIL %s result: latency=%0d energy=%0d busy=%b, required latency=%0d energy=%0d busy=0", name, c, energy, busy, P, ee);
    end
  endtask

  task automatic test_reset();
    #3;
    vec++;
    if (spins !== '0 || energy !== '0 || busy !== 1'b0 || valid !== 1'b0) begin
      err++;
      $display("FAIL reset_init: spins=%b energy=%0d busy=%b valid=%b, required all 0", spins, energy, busy, valid);
    end
    @(negedge clk) n_rst = 1'b1;
  endtask

  task automatic test_ferro();
    set_ph(0, 0, 0, 0);
    set_j(32'sh00010000, 32'sh00010000, 32'sh00010000);
    run_and_check("ferro");
    vec++;
    if (spins !== 4'b1111 || energy !== -AW'(393216)) begin
      err++;
      $display("FAIL ferro_const: spins=%b energy=%0d, required 1111 -393216", spins, energy);
    end
    repeat (5) @(negedge clk);
    vec++;
    if (valid !== 1'b1 || energy !== -AW'(393216) || spins !== 4'b1111) begin
      err++;
      $display("FAIL ferro_hold: valid=%b energy=%0d spins=%b, required 1 -393216 1111", valid, energy, spins);
    end
  endtask

  task automatic test_alternating();
    set_ph(0, 32'h00008000, 0, 32'h00008000);
    set_j(32'sh00010000, 32'sh00010000, 32'sh00010000);
    run_and_check("alternating");
    vec++;
    if (spins !== 4'b0101 || energy !== AW'(131072)) begin
      err++;
      $display("FAIL alternating_const: spins=%b energy=%0d, required 0101 131072", spins, energy);
    end
  endtask

  task automatic test_boundary();
    set_ph(32'h00004000, 32'h0000C000, 32'hFFFFC000, 32'h00013FFF);
    set_j(32'sh00010000, 0, 0);
    run_and_check("boundary");
    vec++;
    if (spins !== 4'b1110) begin
      err++;
      $display("FAIL boundary_const: spins=%b, required 1110", spins);
    end
  endtask

  task automatic test_triangle();
    set_ph(0, 0, 0, 0);
    set_j(0, 32'sh00050000, 32'sh7FFFFFFF);
    run_and_check("triangle_zero");
    vec++;
    if (energy !== '0) begin
      err++;
      $display("FAIL triangle_zero_const: energy=%0d, required 0", energy);
    end
    J[0][3] = 32'sh80000000;
    run_and_check("triangle_min");
    vec++;
    if (energy !== AW'(64'sd2147483648)) begin
      err++;
      $display("FAIL triangle_min_const: energy=%0d, required 2147483648", energy);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 10; t++) begin
      for (int a = 0; a < N; a++) begin
        ph[a] = $urandom;
        for (int b = 0; b < N; b++) J[a][b] = $urandom;
      end
      run_and_check($sformatf("random%0d", t));
    end
  endtask

  task automatic test_reset_midrun();
    set_ph(0, 32'h00008000, 0, 0);
    set_j(32'sh00030000, 32'sh00010000, 32'sh00020000);
    pulse_start();
    repeat (2) @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    vec++;
    if (spins !== '0 || energy !== '0 || busy !== 1'b0 || valid !== 1'b0) begin
      err++;
      $display("FAIL reset_midrun: spins=%b energy=%0d busy=%b valid=%b, required all 0", spins, energy, busy, valid);
    end
    @(negedge clk) n_rst = 1'b1;
    run_and_check("after_reset");
  endtask

  task automatic test_back_to_back();
    int c;
    longint e_old, e_new;
    logic [N-1:0] s_new;
    set_ph(0, 32'h00009000, 32'h00002000, 32'h0000A000);
    for (int a = 0; a < N; a++)
      for (int b = 0; b < N; b++) J[a][b] = 32'(a * 7 - b * 3) <<< 14;
    e_old = ref_energy();
    pulse_start();
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_valid(c);
    vec++;
    if (c + 3 != P || energy !== AW'(e_old)) begin
      err++;
      $display("FAIL ignore_start: latency=%0d energy=%0d, required latency=%0d energy=%0d", c + 3, energy, P, e_old);
    end
    set_ph(32'h00008000, 0, 32'h00008000, 0);
    set_j(32'sh00020000, 0, 0);
    s_new = ref_spins();
    e_new = ref_energy();
    pulse_start();
    vec++;
    if (valid !== 1'b0 || energy !== AW'(e_old) || spins !== s_new) begin
      err++;
      $display("FAIL restart_hold: valid=%b energy=%0d spins=%b, required valid=0 energy=%0d spins=%b", valid, energy, spins, e_old, s_new);
    end
    wait_valid(c);
    vec++;
    if (c != P || energy !== AW'(e_new)) begin
      err++;
      $display("FAIL restart_result: latency=%0d energy=%0d, required latency=%0d energy=%0d", c, energy, P, e_new);
    end
  endtask

  initial begin
    set_ph(0, 0, 0, 0);
    set_j(0, 0, 0);
    test_reset();
    test_ferro();
    test_alternating();
    test_boundary();
    test_triangle();
    test_random();
    test_reset_midrun();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule

// File: doc/ising_readout.md
Name: ising_readout

Overview:
- Result-side reader for the Ising oscillator core. On a start pulse (driven from the core's done), it decodes the N final oscillator phases into binary spins.
- It then sequentially computes the Ising energy E = -sum over i<j of J[i][j]*s_i*s_j from the same coupling matrix the core used.
- Its results (spin vector plus energy) feed the host readout and solution-quality logic.

Parameters:
- N, 16, number of oscillators/spins; N >= 2 is required (elaboration-time assertion).
- fractionalBits, 16, fractional bits of phase and coupling fixed-point values.
- dataWidth, 32, width of phase and coupling words (signed two's complement).
- ACC_WIDTH, dataWidth+2*$clog2(N), width of the energy accumulator/output.

Ports:
- clk  in  1  clock.
- n_rst  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request; samples finalPhases and begins the energy pass.
- couplingMatrix  in  signed dataWidth x [N][N]  coupling J[i][j]; the source must hold it stable while busy=1.
- finalPhases  in  signed dataWidth x [N]  oscillator phases. 1.0 (fixed point) = one full cycle (2*pi).
- spins  out  N  decoded spin vector; bit i=1 means s_i=+1, bit i=0 means s_i=-1.
- energy  out  signed ACC_WIDTH  last completed energy, same fixed-point scaling as J.
- busy  out  1  high while the accumulation pass is running.
- valid  out  1  high while spins/energy hold a completed result.

Behaviour:
- Reset (async, n_rst=0): state=IDLE, spins=0, energy=0, busy=0, valid=0, accumulator=0, pair indices=0.
- Spin decode uses fractional bits p[fractionalBits-1:fractionalBits-2] of each phase. Integer bits are ignored, so wrap-around and negative phases come for free.
  - Bits 00 or 11 give s=+1 (cos>=0).
  - Bits 01 or 10 give s=-1.
  - Exactly 0.25 turn (01 followed by zeros) gives -1. Exactly 0.75 turn (11 followed by zeros) gives +1.
- State machine has two states, IDLE and ACCUM.
  - IDLE with start=1, at edge k: spins register decoded phases; acc<=0; i<=0, j<=1; busy<=1; valid<=0; state<=ACCUM.
  - ACCUM, each edge:
    - acc <= acc - (s_i*s_j ? +J[i][j] : -J[i][j]), where J is sign-extended to ACC_WIDTH and the product is realised as an add/subtract (no multiplier).
    - Then advance: j<=j+1. If j==N-1, then i<=i+1 and j<=i+2.
  - ACCUM on the last pair (i=N-2, j=N-1): energy<=final acc value including this term; valid<=1; busy<=0; state<=IDLE.
- Latency: P=N(N-1)/2 edges after the start edge. With N=16, P=120, and valid/energy are updated at edge k+120.
- Only the strict upper triangle is read. The diagonal and lower triangle never affect energy.
- start while busy=1 is ignored: no restart, no effect on indices or accumulator.
- start in IDLE while valid=1 begins a new run. valid drops at that edge; energy keeps the old value until the new completion; spins update immediately.
- energy and spins are held indefinitely after completion until the next start or reset.
- Reset mid-pass aborts immediately to reset values. No partial energy is ever presented.
- Overflow is impossible by construction: P*2^(dataWidth-1) < 2^(ACC_WIDTH-1). No saturation logic.

Decomposition:
- Shared package ising_pkg holds:
  - state_t enum {IDLE, ACCUM};
  - the spin-decode function (phase word -> 1-bit spin);
  - the ACC_WIDTH derivation constant function.
- One natural sub-module, ising_pair_counter: generates the (i,j) upper-triangle sequence with first/last flags, and has init/advance inputs.
- The accumulator and FSM stay in the top module.

Test Plan:
(All cases use N=4, fractionalBits=16, dataWidth=32, so P=6.)
- Reset: assert n_rst=0 mid-run -> spins=0, energy=0, busy=0, valid=0 asynchronously. A subsequent start works normally.
- Uniform ferro: all phases 0, all J=0x00010000 -> spins=4'b1111. valid rises 6 edges after the start edge. energy=-6.0=-393216.
- Alternating: phases {0, 0x00008000, 0, 0x00008000}, all J=1.0 -> spins=4'b0101, energy=+2.0=131072.
- Boundary decode: phases {0x00004000, 0x0000C000, 0xFFFFC000, 0x00013FFF} -> spins=4'b1110 (s0=-1, s1=+1, s2=+1, s3=+1).
- Triangle isolation: upper-triangle J=0, diagonal=0x00050000, lower=0x7FFFFFFF, phases 0 -> energy=0 with no overflow. Second run with J[0][3]=0x80000000 only -> energy=+2147483648.
- Handshake: pulse start again at cycle 3 of a run -> ignored; result and timing identical to the single-start run. Start after valid -> valid drops that edge, the old energy is held, and the new energy appears 6 edges later.
